// File: rtl/tpu_sched_pkg.sv
// Shared types and helpers for the tiled matmul scheduler: FSM states, default
// index widths and the tile base-address calculation.
package tpu_sched_pkg;

  localparam int unsigned ARR_DIM_DEF      = 16;
  localparam int unsigned MAX_OUT_ROWS_DEF = 128;
  localparam int unsigned MAX_OUT_COLS_DEF = 128;
  localparam int unsigned MAX_K_DEF        = 128;

  localparam int unsigned RT_W = $clog2(MAX_OUT_ROWS_DEF / ARR_DIM_DEF);
  localparam int unsigned CT_W = $clog2(MAX_OUT_COLS_DEF / ARR_DIM_DEF);
  localparam int unsigned KT_W = $clog2(MAX_K_DEF / ARR_DIM_DEF);

  typedef enum logic [2:0] {
    StIdle,
    StWLoad,
    StWPush,
    StDCalc,
    StWWait
  } sched_state_e;

  // Tile base = base + (major * span + minor) * words; the caller truncates,
  // so the result wraps modulo the memory address space.
  function automatic logic [31:0] tile_addr(input logic [31:0] base,
                                            input logic [31:0] major,
                                            input logic [31:0] span,
                                            input logic [31:0] minor,
                                            input logic [31:0] words);
    return base + (major * span + minor) * words;
  endfunction

endpackage

// File: rtl/tile_iter.sv
// Nested r/c/k tile counter (k innermost) with a combinational lookahead of the
// following index and a last-tile flag.
module tile_iter #(
  parameter int unsigned RT_W = 3,
  parameter int unsigned CT_W = 3,
  parameter int unsigned KT_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            adv_i,
  input  logic [RT_W-1:0] r_max_i,
  input  logic [CT_W-1:0] c_max_i,
  input  logic [KT_W-1:0] k_max_i,
  output logic [RT_W-1:0] r_o,
  output logic [CT_W-1:0] c_o,
  output logic [KT_W-1:0] k_o,
  output logic            is_last_o,
  output logic [RT_W-1:0] nxt_r_o,
  output logic [CT_W-1:0] nxt_c_o,
  output logic [KT_W-1:0] nxt_k_o
);

  logic [RT_W-1:0] r_q, r_d;
  logic [CT_W-1:0] c_q, c_d;
  logic [KT_W-1:0] k_q, k_d;
  logic            k_wrap, c_wrap, r_wrap;

  always_comb begin
    k_wrap  = (k_q == k_max_i);
    c_wrap  = (c_q == c_max_i);
    r_wrap  = (r_q == r_max_i);

    nxt_k_o = k_wrap ? '0 : k_q + KT_W'(1);
    nxt_c_o = c_q;
    nxt_r_o = r_q;
    if (k_wrap) begin
      nxt_c_o = c_wrap ? '0 : c_q + CT_W'(1);
      if (c_wrap) begin
        nxt_r_o = r_wrap ? '0 : r_q + RT_W'(1);
      end
    end
    is_last_o = k_wrap && c_wrap && r_wrap;

    r_d = r_q;
    c_d = c_q;
    k_d = k_q;
    if (clear_i) begin
      r_d = '0;
      c_d = '0;
      k_d = '0;
    end else if (adv_i) begin
      r_d = nxt_r_o;
      c_d = nxt_c_o;
      k_d = nxt_k_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
      k_q <= k_d;
    end
  end

  assign r_o = r_q;
  assign c_o = c_q;
  assign k_o = k_q;

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Walks output tiles (r, c) and inner tiles (k), issuing weight load, weight push
// and data stream/accumulate per tile, prefetching the next tile's weights.
module matmul_tile_scheduler #(
  parameter  int unsigned ARR_DIM      = 16,
  parameter  int unsigned MAX_OUT_ROWS = 128,
  parameter  int unsigned MAX_OUT_COLS = 128,
  parameter  int unsigned MAX_K        = 128,
  parameter  int unsigned ADDR_W       = 16,
  parameter  int unsigned TILE_WORDS   = ARR_DIM,
  localparam int unsigned RT_W         = $clog2(MAX_OUT_ROWS / ARR_DIM),
  localparam int unsigned CT_W         = $clog2(MAX_OUT_COLS / ARR_DIM),
  localparam int unsigned KT_W         = $clog2(MAX_K / ARR_DIM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [RT_W-1:0]   cfg_row_tiles_m1_i,
  input  logic [CT_W-1:0]   cfg_col_tiles_m1_i,
  input  logic [KT_W-1:0]   cfg_k_tiles_m1_i,
  input  logic [ADDR_W-1:0] cfg_base_weight_i,
  input  logic [ADDR_W-1:0] cfg_base_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              wl_start_o,
  output logic [ADDR_W-1:0] wl_addr_o,
  input  logic              wl_done_i,
  output logic              wp_start_o,
  input  logic              wp_done_i,
  output logic              dc_start_o,
  output logic [ADDR_W-1:0] dc_addr_o,
  output logic [RT_W-1:0]   dc_accum_row_o,
  output logic [CT_W-1:0]   dc_accum_col_o,
  output logic              dc_overwrite_o,
  input  logic              dc_done_i
);

  import tpu_sched_pkg::*;

  sched_state_e state_q, state_d;

  logic [RT_W-1:0]   row_m1_q, row_m1_d;
  logic [CT_W-1:0]   col_m1_q, col_m1_d;
  logic [KT_W-1:0]   k_m1_q, k_m1_d;
  logic [ADDR_W-1:0] base_w_q, base_w_d;
  logic [ADDR_W-1:0] base_d_q, base_d_d;

  logic              done_q, done_d;
  logic              wl_start_q, wl_start_d;
  logic [ADDR_W-1:0] wl_addr_q, wl_addr_d;
  logic              wp_start_q, wp_start_d;
  logic              dc_start_q, dc_start_d;
  logic [ADDR_W-1:0] dc_addr_q, dc_addr_d;
  logic [RT_W-1:0]   dc_row_q, dc_row_d;
  logic [CT_W-1:0]   dc_col_q, dc_col_d;
  logic              dc_ovw_q, dc_ovw_d;

  // pf_pend: prefetch load issued, not yet completed; pf_done: completed, not yet pushed.
  logic              pf_pend_q, pf_pend_d;
  logic              pf_done_q, pf_done_d;

  logic              iter_clear, cur_adv, pf_adv;

  logic [RT_W-1:0]   cur_r, cur_nxt_r, pf_r, pf_nxt_r;
  logic [CT_W-1:0]   cur_c, cur_nxt_c, pf_c, pf_nxt_c;
  logic [KT_W-1:0]   cur_k, cur_nxt_k, pf_k, pf_nxt_k;
  logic              cur_last, pf_last;

  // Compute index: tile currently being pushed/streamed.
  tile_iter #(
    .RT_W (RT_W),
    .CT_W (CT_W),
    .KT_W (KT_W)
  ) u_cur_iter (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (iter_clear),
    .adv_i     (cur_adv),
    .r_max_i   (row_m1_q),
    .c_max_i   (col_m1_q),
    .k_max_i   (k_m1_q),
    .r_o       (cur_r),
    .c_o       (cur_c),
    .k_o       (cur_k),
    .is_last_o (cur_last),
    .nxt_r_o   (cur_nxt_r),
    .nxt_c_o   (cur_nxt_c),
    .nxt_k_o   (cur_nxt_k)
  );

  // Prefetch index: tile whose weights were most recently requested.
  tile_iter #(
    .RT_W (RT_W),
    .CT_W (CT_W),
    .KT_W (KT_W)
  ) u_pf_iter (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (iter_clear),
    .adv_i     (pf_adv),
    .r_max_i   (row_m1_q),
    .c_max_i   (col_m1_q),
    .k_max_i   (k_m1_q),
    .r_o       (pf_r),
    .c_o       (pf_c),
    .k_o       (pf_k),
    .is_last_o (pf_last),
    .nxt_r_o   (pf_nxt_r),
    .nxt_c_o   (pf_nxt_c),
    .nxt_k_o   (pf_nxt_k)
  );

  logic unused_iter;
  assign unused_iter = ^{cur_nxt_r, cur_nxt_c, cur_nxt_k, pf_r, pf_c, pf_k, pf_last, pf_nxt_r};

  always_comb begin
    state_d    = state_q;
    row_m1_d   = row_m1_q;
    col_m1_d   = col_m1_q;
    k_m1_d     = k_m1_q;
    base_w_d   = base_w_q;
    base_d_d   = base_d_q;
    done_d     = 1'b0;
    wl_start_d = 1'b0;
    wp_start_d = 1'b0;
    dc_start_d = 1'b0;
    wl_addr_d  = wl_addr_q;
    dc_addr_d  = dc_addr_q;
    dc_row_d   = dc_row_q;
    dc_col_d   = dc_col_q;
    dc_ovw_d   = dc_ovw_q;
    pf_pend_d  = pf_pend_q;
    pf_done_d  = pf_done_q;
    iter_clear = 1'b0;
    cur_adv    = 1'b0;
    pf_adv     = 1'b0;

    if (wl_done_i && pf_pend_q) begin
      pf_pend_d = 1'b0;
      pf_done_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          row_m1_d   = cfg_row_tiles_m1_i;
          col_m1_d   = cfg_col_tiles_m1_i;
          k_m1_d     = cfg_k_tiles_m1_i;
          base_w_d   = cfg_base_weight_i;
          base_d_d   = cfg_base_data_i;
          iter_clear = 1'b1;
          wl_start_d = 1'b1;
          wl_addr_d  = cfg_base_weight_i;
          pf_pend_d  = 1'b0;
          pf_done_d  = 1'b0;
          state_d    = StWLoad;
        end
      end
      StWLoad: begin
        if (wl_done_i) begin
          wp_start_d = 1'b1;
          state_d    = StWPush;
        end
      end
      StWPush: begin
        if (wp_done_i) begin
          dc_start_d = 1'b1;
          dc_addr_d  = ADDR_W'(tile_addr(32'(base_d_q), 32'(cur_r), 32'(k_m1_q) + 32'd1,
                                         32'(cur_k), 32'(TILE_WORDS)));
          dc_row_d   = cur_r;
          dc_col_d   = cur_c;
          dc_ovw_d   = (cur_k == '0);
          state_d    = StDCalc;
          if (!cur_last) begin
            pf_adv     = 1'b1;
            wl_start_d = 1'b1;
            wl_addr_d  = ADDR_W'(tile_addr(32'(base_w_q), 32'(pf_nxt_k), 32'(col_m1_q) + 32'd1,
                                           32'(pf_nxt_c), 32'(TILE_WORDS)));
            pf_pend_d  = 1'b1;
          end
        end
      end
      StDCalc: begin
        if (dc_done_i) begin
          if (cur_last) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cur_adv = 1'b1;
            // A load completing in the same cycle counts as already prefetched.
            if (pf_done_q || (wl_done_i && pf_pend_q)) begin
              wp_start_d = 1'b1;
              pf_done_d  = 1'b0;
              state_d    = StWPush;
            end else begin
              state_d = StWWait;
            end
          end
        end
      end
      StWWait: begin
        if (wl_done_i) begin
          wp_start_d = 1'b1;
          pf_done_d  = 1'b0;
          state_d    = StWPush;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      row_m1_q   <= '0;
      col_m1_q   <= '0;
      k_m1_q     <= '0;
      base_w_q   <= '0;
      base_d_q   <= '0;
      done_q     <= 1'b0;
      wl_start_q <= 1'b0;
      wl_addr_q  <= '0;
      wp_start_q <= 1'b0;
      dc_start_q <= 1'b0;
      dc_addr_q  <= '0;
      dc_row_q   <= '0;
      dc_col_q   <= '0;
      dc_ovw_q   <= 1'b0;
      pf_pend_q  <= 1'b0;
      pf_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_m1_q   <= row_m1_d;
      col_m1_q   <= col_m1_d;
      k_m1_q     <= k_m1_d;
      base_w_q   <= base_w_d;
      base_d_q   <= base_d_d;
      done_q     <= done_d;
      wl_start_q <= wl_start_d;
      wl_addr_q  <= wl_addr_d;
      wp_start_q <= wp_start_d;
      dc_start_q <= dc_start_d;
      dc_addr_q  <= dc_addr_d;
      dc_row_q   <= dc_row_d;
      dc_col_q   <= dc_col_d;
      dc_ovw_q   <= dc_ovw_d;
      pf_pend_q  <= pf_pend_d;
      pf_done_q  <= pf_done_d;
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign wl_start_o     = wl_start_q;
  assign wl_addr_o      = wl_addr_q;
  assign wp_start_o     = wp_start_q;
  assign dc_start_o     = dc_start_q;
  assign dc_addr_o      = dc_addr_q;
  assign dc_accum_row_o = dc_row_q;
  assign dc_accum_col_o = dc_col_q;
  assign dc_overwrite_o = dc_ovw_q;

endmodule

// File: doc/matmul_tile_scheduler.md
# matmul_tile_scheduler

Sequences a full tiled matrix multiply on the systolic array by walking output tiles (row, col) and inner-dimension tiles (k), and issuing one three-phase tile operation per step: weight memory→FIFO load, weight FIFO→array push, and data memory→array stream/accumulate. It sits above the per-phase transfer units and drives the accumulator table's submatrix row/column select. It overlaps the next tile's weight load with the current tile's data stream.

## Interface
- ARR_DIM, 16, systolic array width/height; one tile is ARR_DIM×ARR_DIM
- MAX_OUT_ROWS, 128, max output rows
- MAX_OUT_COLS, 128, max output cols
- MAX_K, 128, max inner dimension
- ADDR_W, 16, memory word-address width
- TILE_WORDS, ARR_DIM, memory words per tile (one word = one row of a tile)
- RT_W/CT_W/KT_W (derived), $clog2 of MAX_OUT_ROWS/ARR_DIM, MAX_OUT_COLS/ARR_DIM, MAX_K/ARR_DIM

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin job; sampled only in IDLE
- cfg_row_tiles_m1  in  RT_W  output row tiles minus 1
- cfg_col_tiles_m1  in  CT_W  output col tiles minus 1
- cfg_k_tiles_m1  in  KT_W  inner tiles minus 1
- cfg_base_weight  in  ADDR_W  weight matrix base address
- cfg_base_data  in  ADDR_W  data matrix base address
- busy  out  1  job in progress
- done  out  1  one-cycle pulse, job complete
- wl_start  out  1  pulse: weight mem→FIFO load
- wl_addr  out  ADDR_W  tile base address for load
- wl_done  in  1  pulse: load complete
- wp_start  out  1  pulse: FIFO→array push
- wp_done  in  1  pulse: push complete, FIFO empty
- dc_start  out  1  pulse: data stream + accumulate
- dc_addr  out  ADDR_W  data tile base address
- dc_accum_row  out  RT_W  accumulator table submatrix row
- dc_accum_col  out  CT_W  accumulator table submatrix col
- dc_overwrite  out  1  1 = first k tile, overwrite accumulator; 0 = add
- dc_done  in  1  pulse: stream complete

## Operation
- Iteration order: r outer, c middle, k inner; tile count = (R+1)(C+1)(K+1).
- Config latched on accepted start; later cfg changes have no effect until next job.
- wl_addr = cfg_base_weight + (k·(C+1) + c)·TILE_WORDS; dc_addr = cfg_base_data + (r·(K+1) + k)·TILE_WORDS; modulo 2^ADDR_W, wrap silently.
- dc_overwrite = (k == 0).
- States: IDLE → W_LOAD (first tile) → W_PUSH → D_CALC → (next tile) W_WAIT or W_PUSH → … → IDLE.
- W_LOAD: wait wl_done → W_PUSH.
- W_PUSH: wait wp_done → D_CALC; concurrently launch prefetch load of next tile (if any).
- D_CALC: wait dc_done. If last tile → IDLE, done pulse. Else if prefetch complete → W_PUSH; else → W_WAIT.
- W_WAIT: wait wl_done → W_PUSH.
- Prefetch-done flag set by wl_done, cleared on wp_start.
- Done inputs arriving in a state not expecting them: ignored, no state change.
- start while busy: ignored.

## Timing
- Reset values: busy=0, done=0, all *_start=0, wl_addr=dc_addr=0, dc_accum_row/col=0, dc_overwrite=0; state IDLE; flags clear.
- start at cycle 0 → busy=1 and wl_start at cycle 1.
- Each *_start is a single-cycle pulse one cycle after the enabling event (done pulse sampled at t → start at t+1); addresses/indices registered with the pulse and held until the next pulse of that channel.
- wp_done at t → dc_start and next-tile wl_start both at t+1.
- wl_done and dc_done same cycle t → wp_start at t+1.
- Last dc_done at t → done=1, busy=0 at t+1.
- Reset mid-operation: next cycle all outputs at reset values, state IDLE; in-flight done pulses afterward ignored.

## Structure
- Package tpu_sched_pkg: state enum (IDLE, W_LOAD, W_PUSH, D_CALC, W_WAIT), width localparams RT_W/CT_W/KT_W, address-calc function.
- Sub-module tile_iter: nested r/c/k counter with is_last and next-index lookahead; instantiated twice (compute index, prefetch index).

## Test plan
- 1×1×1 tile, bases 0x0100/0x0200: wl_addr=0x0100, dc_addr=0x0200, dc_overwrite=1, accum (0,0); done 1 cycle after dc_done; no prefetch wl_start.
- R=1,C=0,K=1 (m1 values), TILE_WORDS=16: dc sequence (r,k)=(0,0),(0,1),(1,0),(1,1); dc_addr 0,16,32,48; overwrite 1,0,1,0.
- Prefetch late: wl_done 5 cycles after dc_done → W_WAIT held, wp_start exactly 1 cycle after wl_done.
- wl_done and dc_done same cycle → wp_start next cycle, single pulse.
- Reset asserted during D_CALC, then stray dc_done → all outputs 0, stays IDLE, no done.
- start pulsed while busy and stray wp_done in D_CALC → ignored; job completes with original config and tile count.
